// File: rtl/ahbl_ram_slave.sv
// AHB-Lite slave in front of a word-organised RAM with byte-lane writes and an ERROR response for illegal sizes.
// Latency: read data is registered when the data phase starts; the data phase lasts WAIT_STATES+1 cycles (ERROR is always 2).
// Backpressure: HREADYOUT is held low during wait states and the first ERROR cycle; HREADY gates every address phase.
//
// Ports:
//   HCLK, HRESET            bus clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS,    address phase; accepted when HSEL & HTRANS[1] & HREADY
//   HSIZE, HWRITE, HREADY
//   HWDATA                  write data, valid during the data phase
//   HREADYOUT, HRESP        slave ready and OKAY/ERROR response (both registered)
//   HRDATA                  registered read data, full 32-bit word
module ahbl_ram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  localparam logic [3:0] WS    = 4'(WAIT_STATES);
  localparam int         DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] d_word;
  logic [1:0]            d_lane;
  logic [1:0]            d_size;
  logic                  d_write;

  logic                  accept;
  logic                  size_ok;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] a_word;
  logic [3:0]            be;
  logic [31:0]           rd_fwd;
  logic                  unused_bits;

  assign accept  = HSEL & HTRANS[1] & HREADY;
  assign size_ok = (HSIZE <= 3'd2);
  assign a_word  = HADDR[ADDR_WIDTH+1:2];
  // The write lands on the edge that ends the final data-phase cycle.
  assign commit  = (state == ST_DATA) & d_write;

  // Upper address bits are decoded outside; HTRANS[0] only separates SEQ from NONSEQ.
  assign unused_bits = ^{HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

  // Lane enables from the latched size and low address bits; words are force-aligned.
  always_comb begin
    be = 4'b0000;
    case (d_size)
      2'd0:    be = 4'b0001 << d_lane;
      2'd1:    be = d_lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // A read accepted on the same edge as a committing write to the same word
  // would see the old array contents; merge the in-flight lanes instead.
  always_comb begin
    rd_fwd = mem[a_word];
    for (int i = 0; i < 4; i++) begin
      if (commit && (d_word == a_word) && be[i]) begin
        rd_fwd[8*i +: 8] = HWDATA[8*i +: 8];
      end
    end
  end

  // RAM array: no reset so contents survive HRESET; a write cut short by reset is dropped.
  always_ff @(posedge HCLK) begin
    if (!HRESET && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[d_word][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= 32'h0;
      d_word    <= '0;
      d_lane    <= 2'd0;
      d_size    <= 2'd0;
      d_write   <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt == 4'd1) begin
            // Leaving the last wait cycle: load read data as DATA begins.
            state     <= ST_DATA;
            cnt       <= 4'd0;
            HREADYOUT <= 1'b1;
            if (!d_write) begin
              HRDATA <= mem[d_word];
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all have HREADYOUT high, so a new address phase may land here.
          if (accept) begin
            d_word  <= a_word;
            d_lane  <= HADDR[1:0];
            d_size  <= HSIZE[1:0];
            d_write <= HWRITE;
            if (!size_ok) begin
              state     <= ST_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
            end else if (WS != 4'd0) begin
              state     <= ST_WAIT;
              cnt       <= WS;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b0;
            end else begin
              state     <= ST_DATA;
              HREADYOUT <= 1'b1;
              HRESP     <= 1'b0;
              if (!HWRITE) begin
                HRDATA <= rd_fwd;
              end
            end
          end else begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahbl_ram_slave.sv
// Bench for ahbl_ram_slave: two instances (0 and 3 wait states) behind a shared master bus.
// Latency: the master driver is fully pipelined and follows HREADY on every address phase.
// Backpressure: the driver holds each address phase until the muxed HREADY is high.
`timescale 1ns/1ps
module tb_ahbl_ram_slave;

  typedef struct packed {
    logic        rd;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  waits;
    logic [7:0]  tag;
  } exp_t;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        sel;
  logic        force0;
  logic        hsel0, hsel3;
  logic        ro0, ro3, rs0, rs3;
  logic [31:0] rd0, rd3;
  logic        m_ro, m_rs;
  logic [31:0] m_rd;

  int   n_checks = 0;
  int   n_err    = 0;
  int   tag_n    = 0;
  exp_t sb[$];

  bit   dp_active = 1'b0;
  int   waitcnt   = 0;
  logic first_resp = 1'b0;
  exp_t mon_e;

  always #5 HCLK = ~HCLK;

  // Two-slave decode: sel picks which RAM the master is talking to.
  assign hsel0  = HSEL & ~sel;
  assign hsel3  = HSEL & sel;
  assign m_ro   = sel ? ro3 : ro0;
  assign m_rs   = sel ? rs3 : rs0;
  assign m_rd   = sel ? rd3 : rd0;
  assign HREADY = force0 ? 1'b0 : m_ro;

  ahbl_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(ro0), .HRDATA(rd0), .HRESP(rs0)
  );

  ahbl_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel3), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(ro3), .HRDATA(rd3), .HRESP(rs3)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: tracks data phases from the bus and scores each completed one
  // against the oldest expectation.
  always @(negedge HCLK) begin
    if (HRESET) begin
      dp_active = 1'b0;
      waitcnt   = 0;
    end else if (dp_active && !m_ro) begin
      waitcnt++;
      if (waitcnt == 1) first_resp = m_rs;
    end else begin
      if (dp_active) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_underflow: data phase completed with no expected entry");
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("xfer%0d_waits", mon_e.tag), 32'(waitcnt), 32'(mon_e.waits));
          check($sformatf("xfer%0d_resp", mon_e.tag), {31'b0, m_rs}, {31'b0, mon_e.err});
          if (waitcnt > 0)
            check($sformatf("xfer%0d_resp_first", mon_e.tag), {31'b0, first_resp}, {31'b0, mon_e.err});
          if (mon_e.rd)
            check($sformatf("xfer%0d_rdata", mon_e.tag), m_rd, mon_e.rdata);
        end
      end
      dp_active = HSEL & HTRANS[1] & HREADY;
      waitcnt   = 0;
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Wait for a negedge where HREADY is high, so the next posedge takes the address phase.
  task automatic wait_ready(input string what);
    for (int i = 0; i < 64; i++) begin
      @(negedge HCLK);
      if (HREADY) return;
    end
    n_checks++;
    n_err++;
    $display("FAIL %s_timeout: HREADY low for 64 cycles", what);
  endtask

  // One pipelined transfer: address phase now, write data driven once accepted.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [31:0] exp_rd);
    exp_t e;
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = a;
    HWRITE = w;
    HSIZE  = sz;
    wait_ready($sformatf("xfer%0d", tag_n));
    step();
    if (w) HWDATA = wd;
    e.err   = (sz >= 3'd3);
    e.rd    = !w && !e.err;
    e.rdata = exp_rd;
    e.waits = e.err ? 4'd1 : (sel ? 4'd3 : 4'd0);
    e.tag   = 8'(tag_n);
    sb.push_back(e);
    tag_n++;
  endtask

  task automatic idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    wait_ready("idle");
    step();
  endtask

  // A cycle that must not start a transfer: HREADYOUT stays high, garbage write data follows.
  task automatic non_xfer(input string name, input logic s, input logic [1:0] t, input logic f0);
    HSEL   = s;
    HTRANS = t;
    HWRITE = 1'b1;
    HADDR  = 32'h30;
    HSIZE  = 3'd2;
    force0 = f0;
    @(negedge HCLK);
    check(name, {31'b0, m_ro}, 32'h1);
    step();
    HWDATA = 32'hFFFF_FFFF;
    force0 = 1'b0;
  endtask

  // Reset for two cycles while the last-issued transfer on dut3 is in its wait states.
  task automatic reset_mid(input string name);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    sb.delete();
    @(negedge HCLK);
    check({name, "_hreadyout"}, {31'b0, ro3}, 32'h1);
    check({name, "_hresp"}, {31'b0, rs3}, 32'h0);
    check({name, "_hrdata"}, rd3, 32'h0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_err++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $fatal(1);
  end

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HSIZE = 3'd0;
    HWRITE = 1'b0; HWDATA = 32'h0; sel = 1'b0; force0 = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    check("rst0_hreadyout", {31'b0, ro0}, 32'h1);
    check("rst0_hresp", {31'b0, rs0}, 32'h0);
    check("rst0_hrdata", rd0, 32'h0);
    check("rst3_hreadyout", {31'b0, ro3}, 32'h1);
    check("rst3_hresp", {31'b0, rs3}, 32'h0);
    check("rst3_hrdata", rd3, 32'h0);
    step();

    // Sized writes, zero wait states; each read directly follows its write.
    xfer(1'b1, 32'h01, 3'd2, 32'h5000_0033, 32'h0);
    xfer(1'b0, 32'h00, 3'd2, 32'h0, 32'h5000_0033);
    xfer(1'b1, 32'h04, 3'd2, 32'h0000_0000, 32'h0);
    xfer(1'b0, 32'h04, 3'd2, 32'h0, 32'h0000_0000);
    xfer(1'b1, 32'h04, 3'd0, 32'hAABB_CCDD, 32'h0);
    xfer(1'b0, 32'h04, 3'd2, 32'h0, 32'h0000_00DD);
    xfer(1'b1, 32'h07, 3'd0, 32'h1122_3344, 32'h0);
    xfer(1'b0, 32'h04, 3'd2, 32'h0, 32'h1100_00DD);
    xfer(1'b1, 32'h08, 3'd2, 32'h0000_0000, 32'h0);
    xfer(1'b1, 32'h0A, 3'd1, 32'h00DB_DBDB, 32'h0);
    xfer(1'b0, 32'h08, 3'd2, 32'h0, 32'h00DB_0000);
    xfer(1'b1, 32'h09, 3'd1, 32'hDBDB_1234, 32'h0);
    xfer(1'b0, 32'h08, 3'd2, 32'h0, 32'h00DB_1234);
    xfer(1'b1, 32'h0A, 3'd1, 32'hDBDB_5678, 32'h0);
    xfer(1'b0, 32'h08, 3'd2, 32'h0, 32'hDBDB_1234);
    idle();

    // Forwarding: stale contents are all-ones.
    xfer(1'b1, 32'h10, 3'd2, 32'hFFFF_FFFF, 32'h0);
    idle();
    xfer(1'b1, 32'h10, 3'd2, 32'h1234_5678, 32'h0);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, 32'h1234_5678);
    xfer(1'b1, 32'h11, 3'd0, 32'h0000_AB00, 32'h0);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, 32'h1234_AB78);
    idle();

    // ERROR responses, then a normal transfer to the same word.
    xfer(1'b1, 32'h20, 3'd2, 32'hCAFE_F00D, 32'h0);
    xfer(1'b1, 32'h20, 3'd3, 32'hDEAD_BEEF, 32'h0);
    xfer(1'b0, 32'h20, 3'd2, 32'h0, 32'hCAFE_F00D);
    xfer(1'b0, 32'h24, 3'd4, 32'h0, 32'h0);
    xfer(1'b0, 32'h20, 3'd2, 32'h0, 32'hCAFE_F00D);
    idle();

    // Non-transfers must leave word 0x30 alone.
    xfer(1'b1, 32'h30, 3'd2, 32'h1111_1111, 32'h0);
    idle();
    non_xfer("nt_idle", 1'b1, 2'b00, 1'b0);
    non_xfer("nt_busy", 1'b1, 2'b01, 1'b0);
    non_xfer("nt_nosel", 1'b0, 2'b10, 1'b0);
    non_xfer("nt_hready0", 1'b1, 2'b10, 1'b1);
    idle();
    xfer(1'b0, 32'h30, 3'd2, 32'h0, 32'h1111_1111);
    idle();

    // Three wait states on the second slave.
    sel = 1'b1;
    xfer(1'b1, 32'h40, 3'd2, 32'h0BAD_CAFE, 32'h0);
    xfer(1'b0, 32'h40, 3'd2, 32'h0, 32'h0BAD_CAFE);
    xfer(1'b1, 32'h42, 3'd1, 32'hBEEF_0000, 32'h0);
    xfer(1'b0, 32'h40, 3'd2, 32'h0, 32'hBEEF_CAFE);
    xfer(1'b1, 32'h44, 3'd3, 32'h0, 32'h0);
    xfer(1'b0, 32'h40, 3'd2, 32'h0, 32'hBEEF_CAFE);
    idle();

    // Reset mid-read, then mid-write: the dropped write must not land.
    xfer(1'b0, 32'h40, 3'd2, 32'h0, 32'hBEEF_CAFE);
    reset_mid("rst_rd");
    xfer(1'b1, 32'h40, 3'd2, 32'h7777_7777, 32'h0);
    reset_mid("rst_wr");
    xfer(1'b0, 32'h40, 3'd2, 32'h0, 32'hBEEF_CAFE);
    idle();
    sel = 1'b0;

    repeat (4) step();
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
